// File: rtl/addr_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : addr_fifo_buf
// Brief    : Single-clock show-ahead FIFO queueing read-request addresses.
// Revision : 1.0 - initial release
// ============================================================================
module addr_fifo_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   space
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Status is derived from registered count only, so no input reaches an output.
    assign empty  = (count_q == '0);
    assign full   = (count_q == C_DEPTH);
    assign space  = C_DEPTH - count_q;
    assign r_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
    assign w_wr_ok = wr & (~full | rd);
    assign w_rd_ok = rd & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_wr_ok && !w_rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared; reset only invalidates it through the count.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addr_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_fifo_buf
// Brief    : Directed self-checking bench for addr_fifo_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr_fifo_buf;

    logic        clk;
    logic        reset;
    logic [63:0] w_data;
    logic        wr;
    logic        rd;
    logic [63:0] r_data;
    logic        empty;
    logic        full;
    logic [3:0]  space;

    int n_checks;
    int n_errors;

    addr_fifo_buf #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(3)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .w_data (w_data),
        .wr     (wr),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full),
        .space  (space)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        wr = 1'b1; w_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] d);
        check_val(tag, r_data, d);
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;

        // Reset
        tick(); tick();
        reset = 1'b0;
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_full",  64'(full),  64'd0);
        check_val("rst_space", 64'(space), 64'd8);
        check_val("rst_rdata", r_data,     64'd0);

        // Single write then read
        push(64'hDEADBEEF_00000001);
        check_val("sw_empty", 64'(empty), 64'd0);
        check_val("sw_space", 64'(space), 64'd7);
        check_val("sw_rdata", r_data,     64'hDEADBEEF_00000001);
        rd = 1'b1; tick(); rd = 1'b0;
        check_val("sr_empty", 64'(empty), 64'd1);
        check_val("sr_space", 64'(space), 64'd8);
        check_val("sr_rdata", r_data,     64'd0);

        // Fill, overflow drop, drain
        for (int i = 1; i <= 8; i++) push(64'(i));
        check_val("fill_full",  64'(full),  64'd1);
        check_val("fill_space", 64'(space), 64'd0);
        check_val("fill_rdata", r_data,     64'd1);
        push(64'd9);
        check_val("ovf_space", 64'(space), 64'd0);
        check_val("ovf_rdata", r_data,     64'd1);
        for (int i = 1; i <= 8; i++) pop_expect("drain1", 64'(i));
        check_val("drain1_empty", 64'(empty), 64'd1);

        // Simultaneous rd & wr while full
        for (int i = 1; i <= 8; i++) push(64'(i));
        rd = 1'b1; wr = 1'b1; w_data = 64'd9;
        tick();
        rd = 1'b0; wr = 1'b0;
        check_val("rw_full",  64'(full), 64'd1);
        check_val("rw_rdata", r_data,    64'd2);
        for (int i = 2; i <= 9; i++) pop_expect("drain2", 64'(i));
        check_val("drain2_empty", 64'(empty), 64'd1);

        // Underflow and rd & wr while empty
        rd = 1'b1; tick(); rd = 1'b0;
        check_val("unf_space", 64'(space), 64'd8);
        check_val("unf_empty", 64'(empty), 64'd1);
        rd = 1'b1; wr = 1'b1; w_data = 64'hA5;
        tick();
        rd = 1'b0; wr = 1'b0;
        check_val("erw_space", 64'(space), 64'd7);
        check_val("erw_rdata", r_data,     64'hA5);
        pop_expect("erw_pop", 64'hA5);

        // Pointer wrap ordering
        for (int i = 0; i < 5; i++) push(64'h100 + 64'(i));
        for (int i = 0; i < 5; i++) pop_expect("wrap5", 64'h100 + 64'(i));
        for (int i = 0; i < 6; i++) push(64'h200 + 64'(i));
        check_val("wrap_space", 64'(space), 64'd2);
        for (int i = 0; i < 6; i++) pop_expect("wrap6", 64'h200 + 64'(i));
        check_val("wrap_empty", 64'(empty), 64'd1);

        // Reset mid-operation with concurrent write
        for (int i = 0; i < 3; i++) push(64'h300 + 64'(i));
        check_val("pre_rst_space", 64'(space), 64'd5);
        reset = 1'b1; wr = 1'b1; w_data = 64'h3FF;
        tick();
        reset = 1'b0; wr = 1'b0;
        check_val("mrst_empty", 64'(empty), 64'd1);
        check_val("mrst_space", 64'(space), 64'd8);
        check_val("mrst_rdata", r_data,     64'd0);
        tick();
        check_val("mrst_hold", 64'(space), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
